// File: rtl/chroma_key_pkg.sv
// -----------------------------------------------------------------------------
// chroma_key_pkg
// Shared definitions for the chroma key / alpha blend pipeline.
//   - mode encodings (bypass, hard key, soft key, matte view)
//   - fixed pipeline latency
//   - colour channel slot indices inside a packed R,G,B pixel (B in the LSBs)
//   - helpers mapping the key-channel parameter to channel slots
// Optional build macro used by the pipeline: SPILL_SUPPRESS_EN.
// -----------------------------------------------------------------------------
package chroma_key_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_HARD   = 2'd1,
    MODE_SOFT   = 2'd2,
    MODE_MATTE  = 2'd3
  } mode_e;

  localparam int LATENCY = 3;

  // Slot index of each channel; slot s occupies bits [s*CW +: CW].
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  // Slot of the key channel: KEY_CH 0 = green, 1 = blue.
  function automatic int key_slot(input int key_ch);
    return (key_ch == 0) ? CH_G : CH_B;
  endfunction

  // Slot of the non-key channel other than red.
  function automatic int other_slot(input int key_ch);
    return (key_ch == 0) ? CH_B : CH_G;
  endfunction

endpackage

// File: rtl/chroma_alpha_calc.sv
// -----------------------------------------------------------------------------
// chroma_alpha_calc
// Two-stage key alpha generator.
//   S1: key channel K, O = max(non-key channels), dominance d = K - O (signed),
//       threshold gate (K >= k_min, both non-key <= nk_max).
//   S2: alpha in 0..2^CW from mode (bypass/hard/soft/matte), optional spill
//       suppression of the foreground key channel (macro SPILL_SUPPRESS_EN).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_pixel         foreground pixel (R,G,B MSB->LSB)
//   i_k_min         minimum key channel value (shadow copy)
//   i_nk_max        maximum non-key channel value (shadow copy)
//   i_mode          key mode (shadow copy)
//   o_alpha         CW+1 bit alpha, 2 cycles after i_pixel
//   o_fg            foreground aligned with o_alpha (spill-adjusted if enabled)
// -----------------------------------------------------------------------------
module chroma_alpha_calc
  import chroma_key_pkg::*;
#(
  parameter int CW         = 8,
  parameter int KEY_CH     = 0,
  parameter int MARGIN     = 20,
  parameter int SOFT_SHIFT = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3*CW-1:0] i_pixel,
  input  logic [CW-1:0]   i_k_min,
  input  logic [CW-1:0]   i_nk_max,
  input  logic [1:0]      i_mode,
  output logic [CW:0]     o_alpha,
  output logic [3*CW-1:0] o_fg
);

  localparam int          KS       = key_slot(KEY_CH);
  localparam int          NS       = other_slot(KEY_CH);
  localparam logic [CW:0] L_FULL   = {1'b1, {CW{1'b0}}};
  localparam logic [CW:0] L_MARGIN = (CW+1)'(MARGIN);
  localparam logic [CW:0] L_BAND   = (CW+1)'(2 ** SOFT_SHIFT);

  // ---------------- S1 ----------------
  logic [CW-1:0] w_k, w_r, w_n, w_o;
  logic [CW:0]   w_d;
  logic          w_gate;

  assign w_k    = i_pixel[KS*CW +: CW];
  assign w_r    = i_pixel[CH_R*CW +: CW];
  assign w_n    = i_pixel[NS*CW +: CW];
  assign w_o    = (w_r > w_n) ? w_r : w_n;
  // Zero-extended subtraction: bit CW set means K < O (negative dominance).
  assign w_d    = {1'b0, w_k} - {1'b0, w_o};
  assign w_gate = (w_k >= i_k_min) && (w_r <= i_nk_max) && (w_n <= i_nk_max);

  logic [CW:0]     r_d;
  logic            r_gate;
  logic [3*CW-1:0] r_fg_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d     <= '0;
      r_gate  <= 1'b0;
      r_fg_s1 <= '0;
    end else begin
      r_d     <= w_d;
      r_gate  <= w_gate;
      r_fg_s1 <= i_pixel;
    end
  end

`ifdef SPILL_SUPPRESS_EN
  logic [CW-1:0] r_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_o <= '0;
    else     r_o <= w_o;
  end
`endif

  // ---------------- S2 ----------------
  logic        w_pos;
  logic [CW:0] w_e, w_soft, w_alpha;
  logic [3*CW-1:0] w_fg;

  // Keyable only when gated and dominance strictly exceeds the margin.
  assign w_pos  = r_gate && !r_d[CW] && (r_d > L_MARGIN);
  assign w_e    = r_d - L_MARGIN;
  // Inside the soft band e < 2^SOFT_SHIFT, so the shift stays below 2^CW.
  assign w_soft = (w_e >= L_BAND) ? L_FULL : (w_e << (CW - SOFT_SHIFT));

  // Matte view shows the soft alpha, the most informative key shape.
  always_comb begin
    w_alpha = '0;
    case (mode_e'(i_mode))
      MODE_HARD:  if (w_pos) w_alpha = L_FULL;
      MODE_SOFT,
      MODE_MATTE: if (w_pos) w_alpha = w_soft;
      default:    w_alpha = '0;
    endcase
  end

  always_comb begin
    w_fg = r_fg_s1;
`ifdef SPILL_SUPPRESS_EN
    // Pixels not fully replaced keep no more key colour than the other channels.
    if ((w_alpha != L_FULL) && (r_fg_s1[KS*CW +: CW] > r_o))
      w_fg[KS*CW +: CW] = r_o;
`endif
  end

  logic [CW:0]     r_alpha;
  logic [3*CW-1:0] r_fg_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alpha <= '0;
      r_fg_s2 <= '0;
    end else begin
      r_alpha <= w_alpha;
      r_fg_s2 <= w_fg;
    end
  end

  assign o_alpha = r_alpha;
  assign o_fg    = r_fg_s2;

endmodule

// File: rtl/chroma_key_blend_pipe.sv
// -----------------------------------------------------------------------------
// chroma_key_blend_pipe
// Chroma keyer with soft alpha and round-to-nearest blend of the camera
// foreground over a background, 3-cycle fixed latency, frame-synchronous
// configuration and a per-frame keyed-pixel counter.
// Optional build macro: SPILL_SUPPRESS_EN (key-colour fringe removal in S2).
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   rgb_data, bg_data   foreground / background pixels (R,G,B MSB->LSB)
//   i_hsync, i_vsync    syncs; i_vsync rising edge = frame boundary
//   i_de                data enable
//   mode                0 bypass, 1 hard, 2 soft, 3 matte (taken at vsync rise)
//   k_min, nk_max       key thresholds (taken at vsync rise)
//   mixed_data          blended pixel
//   o_hsync/o_vsync/o_de syncs delayed by LATENCY
//   key_count           keyed pixels of the last completed frame
//   count_valid         one-cycle pulse when key_count updates
// -----------------------------------------------------------------------------
module chroma_key_blend_pipe
  import chroma_key_pkg::*;
#(
  parameter int CW         = 8,
  parameter int KEY_CH     = 0,
  parameter int MARGIN     = 20,
  parameter int SOFT_SHIFT = 5,
  parameter int CNT_W      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3*CW-1:0]  rgb_data,
  input  logic [3*CW-1:0]  bg_data,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    k_min,
  input  logic [CW-1:0]    nk_max,
  output logic [3*CW-1:0]  mixed_data,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] key_count,
  output logic             count_valid
);

  localparam int          W2     = 2*CW + 2;
  localparam logic [CW:0] L_FULL = {1'b1, {CW{1'b0}}};
  localparam logic [CW:0] L_HALF = (CW+1)'(2 ** (CW-1));

  // ---------------- shadow configuration ----------------
  logic          r_vs_in_d;
  logic          w_vs_rise;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_k_min, r_nk_max;

  assign w_vs_rise = i_vsync && !r_vs_in_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_in_d <= 1'b0;
      r_mode    <= MODE_BYPASS;
      r_k_min   <= '0;
      r_nk_max  <= '0;
    end else begin
      r_vs_in_d <= i_vsync;
      if (w_vs_rise) begin
        r_mode   <= mode;
        r_k_min  <= k_min;
        r_nk_max <= nk_max;
      end
    end
  end

  // ---------------- S1 + S2: alpha ----------------
  logic [CW:0]     w_alpha;
  logic [3*CW-1:0] w_fg;

  chroma_alpha_calc #(
    .CW         (CW),
    .KEY_CH     (KEY_CH),
    .MARGIN     (MARGIN),
    .SOFT_SHIFT (SOFT_SHIFT)
  ) u_alpha (
    .clk      (clk),
    .rst      (rst),
    .i_pixel  (rgb_data),
    .i_k_min  (r_k_min),
    .i_nk_max (r_nk_max),
    .i_mode   (r_mode),
    .o_alpha  (w_alpha),
    .o_fg     (w_fg)
  );

  // ---------------- delay lines ----------------
  // The foreground delay lives in u_alpha; bg needs to meet it at S3.
  logic [3*CW-1:0]    r_bg_dl [0:LATENCY-2];
  logic [LATENCY-1:0] r_hs_dl, r_vs_dl, r_de_dl;
  logic               r_vs_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY-1; i++) r_bg_dl[i] <= '0;
      r_hs_dl    <= '0;
      r_vs_dl    <= '0;
      r_de_dl    <= '0;
      r_vs_out_d <= 1'b0;
    end else begin
      r_bg_dl[0] <= bg_data;
      for (int i = 1; i < LATENCY-1; i++) r_bg_dl[i] <= r_bg_dl[i-1];
      r_hs_dl    <= {r_hs_dl[LATENCY-2:0], i_hsync};
      r_vs_dl    <= {r_vs_dl[LATENCY-2:0], i_vsync};
      r_de_dl    <= {r_de_dl[LATENCY-2:0], i_de};
      r_vs_out_d <= r_vs_dl[LATENCY-1];
    end
  end

  // ---------------- S3: blend ----------------
  logic [3*CW-1:0] w_bg, w_mixed_next;
  logic [CW-1:0]   w_matte;
  logic            w_matte_mode;

  assign w_bg         = r_bg_dl[LATENCY-2];
  assign w_matte_mode = (r_mode == MODE_MATTE);
  assign w_matte      = w_alpha[CW] ? {CW{1'b1}} : w_alpha[CW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [W2-1:0] w_sum;
      logic [CW-1:0] w_blend;
      // Weights sum to 2^CW, so the rounded result never exceeds 2^CW-1.
      assign w_sum   = W2'(w_fg[gi*CW +: CW]) * W2'(L_FULL - w_alpha)
                     + W2'(w_bg[gi*CW +: CW]) * W2'(w_alpha)
                     + W2'(L_HALF);
      assign w_blend = CW'(w_sum >> CW);
      assign w_mixed_next[gi*CW +: CW] = w_matte_mode ? w_matte : w_blend;
    end
  endgenerate

  logic [3*CW-1:0] r_mixed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mixed <= '0;
    else     r_mixed <= w_mixed_next;
  end

  // ---------------- keyed pixel counter ----------------
  logic             w_keyed, w_vs_out_rise;
  logic [CNT_W-1:0] r_cnt, r_key_count;
  logic             r_count_valid;

  // Counted at S2, where de and alpha of the same pixel line up.
  assign w_keyed       = r_de_dl[LATENCY-2] && (w_alpha != '0);
  assign w_vs_out_rise = r_vs_dl[LATENCY-1] && !r_vs_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_key_count   <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      if (w_vs_out_rise) begin
        r_key_count   <= r_cnt;
        r_count_valid <= 1'b1;
        // A keyed pixel on the boundary cycle belongs to the new frame.
        r_cnt         <= w_keyed ? CNT_W'(1) : '0;
      end else if (w_keyed && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign mixed_data  = r_mixed;
  assign o_hsync     = r_hs_dl[LATENCY-1];
  assign o_vsync     = r_vs_dl[LATENCY-1];
  assign o_de        = r_de_dl[LATENCY-1];
  assign key_count   = r_key_count;
  assign count_valid = r_count_valid;

endmodule

// File: tb/tb_chroma_key_blend_pipe.sv
// -----------------------------------------------------------------------------
// tb_chroma_key_blend_pipe
// Bench for chroma_key_blend_pipe with default parameters (CW=8, green key,
// MARGIN=20, SOFT_SHIFT=5, CNT_W=22). Expected pixels come from a table of
// hand-derived values; a scoreboard queue aligns them with the 3-cycle output.
// -----------------------------------------------------------------------------
module tb_chroma_key_blend_pipe;
  import chroma_key_pkg::*;

  localparam int CW    = 8;
  localparam int CNT_W = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic [3*CW-1:0]   rgb_data, bg_data;
  logic              i_hsync, i_vsync, i_de;
  logic [1:0]        mode;
  logic [CW-1:0]     k_min, nk_max;
  logic [3*CW-1:0]   mixed_data;
  logic              o_hsync, o_vsync, o_de;
  logic [CNT_W-1:0]  key_count;
  logic              count_valid;

  always #5 clk = ~clk;

  chroma_key_blend_pipe #(
    .CW(CW), .KEY_CH(0), .MARGIN(20), .SOFT_SHIFT(5), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rgb_data(rgb_data), .bg_data(bg_data),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
    .mode(mode), .k_min(k_min), .nk_max(nk_max),
    .mixed_data(mixed_data),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .key_count(key_count), .count_valid(count_valid)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          chk;
    logic [23:0] px;
    logic        hs, vs, de;
  } sb_t;

  sb_t         sbq[$];
  bit          tb_chk = 1'b0;
  logic [23:0] tb_exp = '0;

  always @(posedge clk) begin : sb_push
    sb_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      e.chk = tb_chk; e.px = tb_exp;
      e.hs = i_hsync; e.vs = i_vsync; e.de = i_de;
      sbq.push_back(e);
    end
  end

  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (!rst && sbq.size() == 3) begin
      e = sbq.pop_front();
      checks++;
      if ({o_hsync, o_vsync, o_de} !== {e.hs, e.vs, e.de}) begin
        errors++;
        $display("FAIL syncs got %b%b%b want %b%b%b", o_hsync, o_vsync, o_de, e.hs, e.vs, e.de);
      end
      if (e.chk) begin
        checks++;
        if (mixed_data !== e.px) begin
          errors++;
          $display("FAIL pixel got %h want %h", mixed_data, e.px);
        end
      end
    end
  end

  logic prev_cv = 1'b0;
  always @(negedge clk) begin
    if (count_valid) begin
      checks++;
      if (prev_cv) begin
        errors++;
        $display("FAIL count_valid_width got 2+ cycles want 1");
      end
    end
    prev_cv <= count_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [23:0] fg, input logic [23:0] bg, input logic hs,
                      input logic vs, input logic de, input bit chk, input logic [23:0] ex);
    rgb_data = fg; bg_data = bg;
    i_hsync = hs; i_vsync = vs; i_de = de;
    tb_chk = chk; tb_exp = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic vsync_pulse();
    step(24'h0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] k, input logic [7:0] n);
    mode = m; k_min = k; nk_max = n;
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({mixed_data, o_hsync, o_vsync, o_de, key_count, count_valid} !== '0) begin
      errors++;
      $display("FAIL %s got mixed=%h sync=%b%b%b cnt=%0d cv=%b want all 0",
               name, mixed_data, o_hsync, o_vsync, o_de, key_count, count_valid);
    end
  endtask

  // Starts a frame and checks the key_count pulse for the frame just ended.
  task automatic wait_count(input int exp_cnt, input string name);
    bit found = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 8 && !found; i++) begin
      step(24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      if (count_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_pulse got none want count_valid", name);
    end else if (key_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, key_count, exp_cnt);
    end
    step(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++;
    if (count_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_width got %b want 0", name, count_valid);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  md;
    logic [7:0]  kmin, nkmax;
    logic [23:0] fg, bg, ex;
  } vec_t;

  vec_t vt [16];

  initial begin
    vt[0]  = '{2'd1, 8'h80, 8'h40, 24'h10C010, 24'hAABBCC, 24'hAABBCC}; // hard keyed
    vt[1]  = '{2'd1, 8'h80, 8'h40, 24'h30C050, 24'hAABBCC, 24'h30C050}; // B > nk_max
    vt[2]  = '{2'd2, 8'h60, 8'h40, 24'h406A30, 24'h000000, 24'h14210F}; // soft a=176
    vt[3]  = '{2'd3, 8'h80, 8'h40, 24'h10C010, 24'hAABBCC, 24'hFFFFFF}; // matte full
    vt[4]  = '{2'd0, 8'h80, 8'h40, 24'h10C010, 24'hAABBCC, 24'h10C010}; // bypass
    vt[5]  = '{2'd1, 8'h50, 8'h40, 24'h405440, 24'h112233, 24'h405440}; // d == MARGIN
    vt[6]  = '{2'd1, 8'h50, 8'h40, 24'h405540, 24'h112233, 24'h112233}; // d == MARGIN+1
    vt[7]  = '{2'd2, 8'h50, 8'h40, 24'h405540, 24'h000000, 24'h3E523E}; // soft e=1
    vt[8]  = '{2'd2, 8'h50, 8'h40, 24'h407340, 24'hFFFFFF, 24'hF9FBF9}; // soft e=31
    vt[9]  = '{2'd2, 8'h50, 8'h40, 24'h407440, 24'hFFFFFF, 24'hFFFFFF}; // soft e=32
    vt[10] = '{2'd1, 8'hC0, 8'h40, 24'h10BF10, 24'hAABBCC, 24'h10BF10}; // K < k_min
    vt[11] = '{2'd1, 8'hC0, 8'h40, 24'h10C010, 24'hAABBCC, 24'hAABBCC}; // K == k_min
    vt[12] = '{2'd1, 8'h80, 8'h10, 24'h10C010, 24'h5A5A5A, 24'h5A5A5A}; // nk == nk_max
    vt[13] = '{2'd1, 8'h80, 8'h10, 24'h11C010, 24'h5A5A5A, 24'h11C010}; // nk > nk_max
    vt[14] = '{2'd3, 8'h50, 8'h40, 24'h405540, 24'hAABBCC, 24'h080808}; // matte a=8
    vt[15] = '{2'd1, 8'h00, 8'hFF, 24'hFF0000, 24'h123456, 24'hFF0000}; // negative d
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    rgb_data = '0; bg_data = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    set_cfg(2'd0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;
    idle(4);

    // Config applied mid-frame is not used until the next vsync rise.
    set_cfg(2'd1, 8'h80, 8'h40);
    step(24'h10C010, 24'hAABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'h10C010);
    idle(3);
    vsync_pulse();
    step(24'h10C010, 24'hAABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    set_cfg(2'd0, 8'h80, 8'h40);
    step(24'h10C010, 24'hAABBCC, 1'b0, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    idle(3);

    for (int i = 0; i < 16; i++) begin
      set_cfg(vt[i].md, vt[i].kmin, vt[i].nkmax);
      vsync_pulse();
      $display("vec %0d mode=%0d kmin=%h nkmax=%h fg=%h bg=%h exp=%h",
               i, vt[i].md, vt[i].kmin, vt[i].nkmax, vt[i].fg, vt[i].bg, vt[i].ex);
      step(vt[i].fg, vt[i].bg, 1'b1, 1'b0, 1'b1, 1'b1, vt[i].ex);
      idle(2);
    end

    // Counter: 640 DE pixels with 100 keyable, then a frame with none.
    set_cfg(2'd1, 8'h80, 8'h40);
    vsync_pulse();
    for (int i = 0; i < 640; i++) begin
      if ((i % 6 == 0) && (i < 600))
        step(24'h10C010, 24'h123456, (i % 64 == 63), 1'b0, 1'b1, 1'b1, 24'h123456);
      else
        step(24'h30C050, 24'h123456, (i % 64 == 63), 1'b0, 1'b1, 1'b1, 24'h30C050);
    end
    idle(3);
    wait_count(100, "key_count_100");
    for (int i = 0; i < 640; i++)
      step(24'h30C050, 24'h123456, (i % 64 == 63), 1'b0, 1'b1, 1'b1, 24'h30C050);
    idle(3);
    wait_count(0, "key_count_0");

    // Reset during active video.
    for (int i = 0; i < 5; i++)
      step(24'h10C010, 24'hAABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    idle(3);
    wait_count(5, "key_count_5");
    for (int i = 0; i < 4; i++)
      step(24'h10C010, 24'hAABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    rst = 1'b1;
    #1;
    chk_zero("reset_async");
    @(posedge clk);
    #1;
    chk_zero("reset_hold");
    rst = 1'b0;
    step(24'h10C010, 24'hAABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'h10C010);
    idle(3);
    vsync_pulse();
    step(24'h10C010, 24'hAABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
